// File: rtl/dispatch_ctrl_if.sv
// Handshake bundle between the decode/ROB side and the dispatch sequencing controller.
// The master side drives decode, commit and mispredict information; the slave is the controller.
interface dispatch_ctrl_if #(
  parameter int TAG_W    = 4,
  parameter int RS_CNT_W = 4
);
  logic                dec1Valid;
  logic                dec2Valid;
  logic [RS_CNT_W-1:0] rsFree;
  logic [1:0]          commitCount;
  logic                mispredict;
  logic [TAG_W-1:0]    mispredTag;

  logic                dispatchWrite;
  logic                flush;
  logic [TAG_W-1:0]    robDest1out;
  logic [TAG_W-1:0]    robDest2out;
  logic                decodeStall;
  logic [1:0]          dispatchCount;
  logic                robFull;
  logic [1:0]          state;

  modport master (
    output dec1Valid, dec2Valid, rsFree, commitCount, mispredict, mispredTag,
    input  dispatchWrite, flush, robDest1out, robDest2out, decodeStall,
           dispatchCount, robFull, state
  );

  modport slave (
    input  dec1Valid, dec2Valid, rsFree, commitCount, mispredict, mispredTag,
    output dispatchWrite, flush, robDest1out, robDest2out, decodeStall,
           dispatchCount, robFull, state
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Sequencing controller for the 2-wide dispatch buffer: capture/hold/bubble decisions,
// ROB tag allocation and occupancy tracking, and mispredict rollback with a fixed flush.
module dispatch_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int TAG_W        = 4,
  parameter int RS_CNT_W     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dispatch_ctrl_if.slave  bus
);

  localparam int CNT_W = TAG_W + 1;
  localparam int FC_W  = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } fsm_t;

  logic [TAG_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  fsm_t             fsm;
  logic [FC_W-1:0]  flush_cnt;

  logic [TAG_W-1:0] head_n, tail_n, rel_tag;
  logic [CNT_W-1:0] count_n, rob_free, commit_ext, disp_ext;
  fsm_t             fsm_n;
  logic [FC_W-1:0]  flush_cnt_n;
  logic [1:0]       need, disp_cnt;
  logic             ok, write_en, flush_en, stall_en;

  // Free space and RS capacity both come from registered/current values, so entries
  // freed by this cycle's commit only become usable on the next cycle.
  always_comb begin
    need     = {1'b0, bus.dec1Valid} + {1'b0, bus.dec1Valid & bus.dec2Valid};
    rob_free = CNT_W'(ROB_DEPTH) - count;
    ok       = (CNT_W'(need) <= rob_free) && ({30'd0, need} <= 32'(bus.rsFree));
  end

  always_comb begin
    write_en    = 1'b1;
    flush_en    = 1'b1;
    stall_en    = 1'b1;
    disp_cnt    = 2'd0;
    fsm_n       = fsm;
    flush_cnt_n = flush_cnt;

    if (bus.mispredict) begin
      fsm_n       = FLUSH;
      flush_cnt_n = FC_W'(FLUSH_CYCLES - 1);
    end else if (fsm == FLUSH) begin
      if (flush_cnt == '0) fsm_n = RUN;
      else                 flush_cnt_n = flush_cnt - FC_W'(1);
    end else if (need == 2'd0) begin
      stall_en = 1'b0;
      fsm_n    = RUN;
    end else if (ok) begin
      flush_en = 1'b0;
      stall_en = 1'b0;
      disp_cnt = need;
      fsm_n    = RUN;
    end else begin
      write_en = 1'b0;
      flush_en = 1'b0;
      fsm_n    = STALL;
    end
  end

  // Rollback keeps everything up to and including the mispredicted branch, measured from the old head.
  always_comb begin
    commit_ext = CNT_W'(bus.commitCount);
    disp_ext   = CNT_W'(disp_cnt);
    rel_tag    = bus.mispredTag - head;
    head_n     = head + TAG_W'(bus.commitCount);
    if (bus.mispredict) begin
      tail_n  = bus.mispredTag + TAG_W'(1);
      count_n = {1'b0, rel_tag} + CNT_W'(1) - commit_ext;
    end else begin
      tail_n  = tail + TAG_W'(disp_cnt);
      count_n = count + disp_ext - commit_ext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      fsm       <= RUN;
      flush_cnt <= '0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      count     <= count_n;
      fsm       <= fsm_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // While reset is held the buffer is continuously written with bubbles.
  always_comb begin
    if (!rst_n) begin
      bus.dispatchWrite = 1'b1;
      bus.flush         = 1'b1;
      bus.decodeStall   = 1'b1;
      bus.dispatchCount = 2'd0;
      bus.robDest1out   = '0;
      bus.robDest2out   = '0;
      bus.robFull       = 1'b0;
      bus.state         = 2'd0;
    end else begin
      bus.dispatchWrite = write_en;
      bus.flush         = flush_en;
      bus.decodeStall   = stall_en;
      bus.dispatchCount = disp_cnt;
      bus.robDest1out   = tail;
      bus.robDest2out   = tail + TAG_W'(1);
      bus.robFull       = (count == CNT_W'(ROB_DEPTH));
      bus.state         = fsm;
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Scoreboard bench for dispatch_ctrl: a queue-of-tags ROB model predicts each cycle's
// outputs, and an independent monitor compares them against the DUT.
module tb_dispatch_ctrl;
  localparam int DEPTH = 16;
  localparam int TW    = 4;
  localparam int RSW   = 4;
  localparam int FC    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dispatch_ctrl_if #(.TAG_W(TW), .RS_CNT_W(RSW)) bus();

  dispatch_ctrl #(
    .ROB_DEPTH(DEPTH), .TAG_W(TW), .RS_CNT_W(RSW), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        dw;
    logic        fl;
    logic        st;
    logic [1:0]  dc;
    logic [TW-1:0] d1;
    logic [TW-1:0] d2;
    logic        full;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];
  int   rob[$];
  int   next_tag   = 0;
  int   mstate     = 0;
  int   flush_left = 0;
  int   cycle      = 0;
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string name, input int cyc,
                             input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs from the ROB tag queue, advances the model.
  task automatic applyStimulus(input logic rst, input logic d1, input logic d2, input int rsf,
                               input int commit, input logic mp, input int mtag);
    exp_t e;
    int   need;
    @(negedge clk);
    rst_n           = rst;
    bus.dec1Valid   = d1;
    bus.dec2Valid   = d2;
    bus.rsFree      = rsf[RSW-1:0];
    bus.commitCount = commit[1:0];
    bus.mispredict  = mp;
    bus.mispredTag  = mtag[TW-1:0];
    cycle++;
    e.cyc = cycle;
    need  = d1 ? (d2 ? 2 : 1) : 0;
    if (!rst) begin
      e.dw = 1; e.fl = 1; e.st = 1; e.dc = 0; e.d1 = 0; e.d2 = 0; e.full = 0; e.state = 0;
      rob.delete();
      next_tag = 0; mstate = 0; flush_left = 0;
    end else begin
      assert (commit <= rob.size()) else $error("[TB] illegal commit %0d with occupancy %0d", commit, rob.size());
      e.d1    = TW'(next_tag);
      e.d2    = TW'((next_tag + 1) % DEPTH);
      e.full  = (rob.size() == DEPTH);
      e.state = 2'(mstate);
      e.dc    = 0;
      if (mp || mstate == 2) begin
        e.dw = 1; e.fl = 1; e.st = 1;
      end else if (need == 0) begin
        e.dw = 1; e.fl = 1; e.st = 0;
      end else if (need <= DEPTH - rob.size() && need <= rsf) begin
        e.dw = 1; e.fl = 0; e.st = 0; e.dc = 2'(need);
      end else begin
        e.dw = 0; e.fl = 0; e.st = 1;
      end

      if (mp) begin
        while (rob.size() > 0 && rob[$] != mtag) void'(rob.pop_back());
        repeat (commit) void'(rob.pop_front());
        next_tag = (mtag + 1) % DEPTH;
        mstate = 2;
        flush_left = FC;
      end else begin
        if (mstate == 2) begin
          flush_left--;
          if (flush_left == 0) mstate = 0;
        end else if (need == 0) begin
          mstate = 0;
        end else if (e.dc != 0) begin
          for (int k = 0; k < need; k++) begin
            rob.push_back(next_tag);
            next_tag = (next_tag + 1) % DEPTH;
          end
          mstate = 0;
        end else begin
          mstate = 1;
        end
        repeat (commit) void'(rob.pop_front());
      end
    end
    exp_q.push_back(e);
  endtask

  // Monitor: samples the DUT just after the stimulus edge settles and checks against the scoreboard.
  initial begin : monitor
    exp_t m;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        checkOutput("dispatchWrite", m.cyc, 32'(bus.dispatchWrite), 32'(m.dw));
        checkOutput("flush",         m.cyc, 32'(bus.flush),         32'(m.fl));
        checkOutput("decodeStall",   m.cyc, 32'(bus.decodeStall),   32'(m.st));
        checkOutput("dispatchCount", m.cyc, 32'(bus.dispatchCount), 32'(m.dc));
        checkOutput("robDest1out",   m.cyc, 32'(bus.robDest1out),   32'(m.d1));
        checkOutput("robDest2out",   m.cyc, 32'(bus.robDest2out),   32'(m.d2));
        checkOutput("robFull",       m.cyc, 32'(bus.robFull),       32'(m.full));
        checkOutput("state",         m.cyc, 32'(bus.state),         32'(m.state));
      end
    end
  end

  initial begin : stimulus
    int   r_commit, r_tag, idx, lim;
    logic r_mp, r_rst;
    bus.dec1Valid = 0; bus.dec2Valid = 0; bus.rsFree = 0;
    bus.commitCount = 0; bus.mispredict = 0; bus.mispredTag = 0;

    repeat (2) applyStimulus(0, 0, 0, 8, 0, 0, 0);
    repeat (3) applyStimulus(1, 0, 0, 8, 0, 0, 0);
    // fill the ROB, stall when full, then free two entries and wrap the tags
    repeat (9) applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 2, 0, 0);
    applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 0, 0, 8, 2, 0, 0);
    repeat (2) applyStimulus(1, 1, 1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 2, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(0, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 0, 0, 8, 0, 0, 0);
    // build head=3, count=8, then roll back to tag 5
    applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 2, 0, 0);
    applyStimulus(1, 1, 1, 8, 1, 0, 0);
    repeat (2) applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 1, 0, 8, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 1, 1, 5);
    repeat (3) applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 0, 1, 5);
    applyStimulus(1, 1, 1, 8, 0, 0, 0);
    applyStimulus(1, 1, 1, 8, 1, 1, 5);
    repeat (3) applyStimulus(1, 1, 1, 8, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      r_rst = ($urandom_range(0, 199) != 0);
      r_mp  = 0;
      r_tag = $urandom_range(0, DEPTH - 1);
      if (rob.size() > 0 && $urandom_range(0, 15) == 0) begin
        idx      = $urandom_range(0, rob.size() - 1);
        r_tag    = rob[idx];
        r_mp     = 1;
        lim      = (idx + 1 < 2) ? idx + 1 : 2;
        r_commit = $urandom_range(0, lim);
      end else begin
        lim      = (rob.size() < 2) ? rob.size() : 2;
        r_commit = ($urandom_range(0, 2) == 0) ? $urandom_range(0, lim) : 0;
      end
      applyStimulus(r_rst, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 15), r_commit, r_mp, r_tag);
    end

    repeat (3) @(negedge clk);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
- Sequencing controller for the 2-wide dispatch pipeline register (dispatch buffer).
- Each cycle it decides whether the buffer captures a new decode pair, holds its contents, or is written with a bubble.
- Allocates ROB destination tags for both slots and tracks ROB occupancy from dispatch and commit.
- Rolls the ROB tail back on a branch mispredict and runs a fixed-length flush sequence.

Parameters:
- ROB_DEPTH, 16, ROB entries; power of two.
- TAG_W, 4, ROB tag width; equals log2(ROB_DEPTH).
- RS_CNT_W, 4, width of the reservation-station free-count input.
- FLUSH_CYCLES, 2, number of bubble cycles after a mispredict; must be at least 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- dec1Valid  in  1  decode slot 1 holds a valid instruction.
- dec2Valid  in  1  decode slot 2 holds a valid instruction; ignored unless dec1Valid=1.
- rsFree  in  RS_CNT_W  number of free reservation-station entries.
- commitCount  in  2  ROB entries retired this cycle (0..2).
- mispredict  in  1  branch mispredict pulse.
- mispredTag  in  TAG_W  ROB tag of the mispredicted branch.
- dispatchWrite  out  1  write enable to the dispatch buffer.
- flush  out  1  flush to the dispatch buffer (write a bubble).
- robDest1out  out  TAG_W  ROB tag allocated to slot 1.
- robDest2out  out  TAG_W  ROB tag allocated to slot 2.
- decodeStall  out  1  hold the decode stage.
- dispatchCount  out  2  instructions dispatched this cycle (0..2).
- robFull  out  1  ROB occupancy equals ROB_DEPTH.
- state  out  2  current state: 0=RUN, 1=STALL, 2=FLUSH.

Behaviour:
- State registers: head, tail (TAG_W bits each), count (TAG_W+1 bits), fsm, flushCnt.
- Outputs are combinational from the registered state and the current inputs. The buffer samples them on the same edge.
- Reset (rst_n=0 at a posedge): head=0, tail=0, count=0, fsm=RUN, flushCnt=0.
- While rst_n=0, outputs are forced: dispatchWrite=1, flush=1, decodeStall=1, dispatchCount=0, robDest1out=0, robDest2out=0, robFull=0, state=0. This scrubs the buffer to bubbles.
- Tag allocation, always driven: robDest1out=tail, robDest2out=(tail+1) mod ROB_DEPTH.
- need = dec1Valid + (dec1Valid & dec2Valid).
- ok = (need <= ROB_DEPTH - count) and (need <= rsFree).
- Dispatch is all-or-nothing per pair; there is no partial dispatch.
- RUN/STALL, mispredict=0:
  - need=0: dispatchWrite=1, flush=1 (bubble), decodeStall=0, next fsm=RUN.
  - need>0 and ok: dispatchWrite=1, flush=0, dispatchCount=need, decodeStall=0, tail+=need, next fsm=RUN.
  - need>0 and !ok: dispatchWrite=0 (buffer holds), decodeStall=1, dispatchCount=0, next fsm=STALL.
  - STALL exits in the same cycle that ok becomes true; the dispatch happens in that cycle.
- Commit, every cycle and in every state: head+=commitCount.
  - count_next = count + dispatchCount - commitCount.
  - commitCount > count is illegal; the bench asserts on it.
- Mispredict (any state):
  - Overrides dispatch: dispatchWrite=1, flush=1, decodeStall=1, dispatchCount=0.
  - tail <= mispredTag+1 mod ROB_DEPTH.
  - count <= ((mispredTag - head) mod ROB_DEPTH) + 1 - commitCount, using pre-update head.
  - fsm <= FLUSH, flushCnt <= FLUSH_CYCLES-1.
- FLUSH:
  - Outputs: dispatchWrite=1, flush=1, decodeStall=1, dispatchCount=0, no allocation.
  - flushCnt decrements each cycle. At flushCnt=0 and no mispredict, next fsm=RUN.
  - A new mispredict during FLUSH re-applies the rollback and reloads flushCnt.
- Pointer wrap: all pointers wrap modulo ROB_DEPTH; count saturates by construction and never exceeds ROB_DEPTH.
- robFull = (count == ROB_DEPTH).
- Dispatch into the last free entry is allowed.
- Commit and dispatch in the same cycle: both apply. Freed entries are not reusable until the next cycle, because ok uses the registered count.

Test Plan:
- Reset then idle, decValid=0 for 3 cycles → dispatchWrite=1, flush=1 every cycle; tail=0; state=RUN.
- dec1/dec2 valid, rsFree=8, 8 cycles with no commits → tags 0/1, 2/3, …, 14/15; robFull=1 after cycle 8; cycle 9 gives dispatchWrite=0, decodeStall=1, state=STALL.
- From full, commitCount=2 → next cycle ok=1, dispatches tags 0/1 (wrap), state=RUN, count=16.
- rsFree=1 with a valid pair → STALL held; rsFree raised to 2 → dispatch in that same cycle.
- head=3, count=8, mispredict with mispredTag=5, commitCount=1 → tail=6, count=2, then 2 FLUSH cycles with flush=1 and decodeStall=1, then RUN.
- Mispredict during the second FLUSH cycle → rollback re-applied; RUN entered only after 2 more cycles. Also: rst_n low mid-STALL → all outputs forced to their reset values and pointers cleared on the next edge.
